// File: rtl/blackjack_pkg.sv
// Shared types for the blackjack datapath: score width, bust threshold and
// display scheduler enums.
package blackjack_pkg;

  typedef logic [5:0] score_t;

  localparam score_t BUST_LIMIT = 6'd21;

  typedef enum logic {SRC_PLAYER, SRC_DEALER} src_e;

  typedef enum logic [1:0] {EMPTY, SHOW, SWITCH} disp_state_e;

  function automatic logic is_bust(score_t v);
    return v > BUST_LIMIT;
  endfunction

endpackage

// File: rtl/mod_counter.sv
// Free-running modulo counter with enable, synchronous clear and a
// terminal-count flag that stays high while the count sits at MODULUS-1.
module mod_counter #(
  parameter int MODULUS = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tc
);

  localparam int W = (MODULUS > 1) ? $clog2(MODULUS) : 1;
  localparam logic [W-1:0] LAST = W'(MODULUS - 1);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= (count == LAST) ? '0 : count + 1'b1;
    end
  end

  assign tc = (count == LAST);

endmodule

// File: rtl/score_display_sched.sv
// Shares one two-digit display between the player and dealer scores,
// rotating between occupied slots on a dwell timer and blinking bust totals.
module score_display_sched
  import blackjack_pkg::*;
#(
  parameter int DWELL_CYCLES = 1000,
  parameter int BLINK_CYCLES = 250
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       p_valid,
  input  logic [5:0] p_score,
  output logic       p_ready,
  input  logic       d_valid,
  input  logic [5:0] d_score,
  output logic       d_ready,
  input  logic       hold,
  input  logic       clr,
  output logic [5:0] mag_result,
  output logic       src_sel,
  output logic       blank,
  output logic       bust
);

  disp_state_e state;
  src_e        src_q;
  score_t      p_val, d_val, mag_q;
  logic        p_vld, d_vld, rdy_en, bust_q, blank_q;
  logic        p_xfer, d_xfer, sel_xfer, other_vld_nxt, switch_go;
  logic        dwell_tc, blink_tc;
  score_t      sel_score, other_score_nxt;

  // rdy_en keeps both readies low until the first edge after reset release
  assign p_ready = rdy_en && (state != SWITCH);
  assign d_ready = rdy_en && (state != SWITCH);
  assign p_xfer  = p_valid && p_ready && !clr;
  assign d_xfer  = d_valid && d_ready && !clr;

  // The other slot is judged after this cycle's writes so a rotation never shows stale data
  always_comb begin
    if (src_q == SRC_DEALER) begin
      sel_xfer        = d_xfer;
      sel_score       = d_score;
      other_vld_nxt   = p_vld || p_xfer;
      other_score_nxt = p_xfer ? p_score : p_val;
    end else begin
      sel_xfer        = p_xfer;
      sel_score       = p_score;
      other_vld_nxt   = d_vld || d_xfer;
      other_score_nxt = d_xfer ? d_score : d_val;
    end
  end

  assign switch_go = (state == SHOW) && dwell_tc && !hold && other_vld_nxt;

  mod_counter #(.MODULUS(DWELL_CYCLES)) u_dwell (
    .clk   (clk),
    .rst_n (rst_n),
    .en    ((state == SHOW) && !hold),
    .clr   (clr || (state != SHOW) || switch_go),
    .tc    (dwell_tc)
  );

  mod_counter #(.MODULUS(BLINK_CYCLES)) u_blink (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (bust_q),
    .clr   (clr || (state != SHOW) || !bust_q || switch_go),
    .tc    (blink_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_vld <= 1'b0;
      d_vld <= 1'b0;
      p_val <= '0;
      d_val <= '0;
    end else if (clr) begin
      p_vld <= 1'b0;
      d_vld <= 1'b0;
    end else begin
      if (p_xfer) begin
        p_vld <= 1'b1;
        p_val <= p_score;
      end
      if (d_xfer) begin
        d_vld <= 1'b1;
        d_val <= d_score;
      end
    end
  end

  // Display FSM; a write that keeps an already-bust value bust continues the blink phase
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= EMPTY;
      src_q   <= SRC_PLAYER;
      mag_q   <= '0;
      bust_q  <= 1'b0;
      blank_q <= 1'b1;
      rdy_en  <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      if (clr) begin
        state   <= EMPTY;
        src_q   <= SRC_PLAYER;
        bust_q  <= 1'b0;
        blank_q <= 1'b1;
      end else begin
        case (state)
          EMPTY: begin
            if (p_xfer || d_xfer) begin
              state   <= SHOW;
              src_q   <= p_xfer ? SRC_PLAYER : SRC_DEALER;
              mag_q   <= p_xfer ? p_score : d_score;
              bust_q  <= is_bust(p_xfer ? p_score : d_score);
              blank_q <= 1'b0;
            end
          end
          SHOW: begin
            if (switch_go) begin
              state   <= SWITCH;
              src_q   <= (src_q == SRC_PLAYER) ? SRC_DEALER : SRC_PLAYER;
              mag_q   <= other_score_nxt;
              bust_q  <= is_bust(other_score_nxt);
              blank_q <= 1'b0;
            end else if (sel_xfer && is_bust(sel_score)) begin
              mag_q   <= sel_score;
              bust_q  <= 1'b1;
              blank_q <= bust_q ? (blank_q ^ blink_tc) : 1'b0;
            end else if (sel_xfer) begin
              mag_q   <= sel_score;
              bust_q  <= 1'b0;
              blank_q <= 1'b0;
            end else if (bust_q && blink_tc) begin
              blank_q <= ~blank_q;
            end
          end
          SWITCH: state <= SHOW;
          default: state <= EMPTY;
        endcase
      end
    end
  end

  assign mag_result = mag_q;
  assign src_sel    = src_q;
  assign bust       = bust_q;
  assign blank      = blank_q;

endmodule

// File: tb/tb_score_display_sched.sv
// Randomised scoreboard bench for score_display_sched against a cycle-level
// behavioural model of the slot/rotation/blink rules.
module tb_score_display_sched;

  localparam int DWELL = 8;
  localparam int BLINK = 3;
  localparam int LIMIT = 21;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       p_valid = 1'b0, d_valid = 1'b0, hold = 1'b0, clr = 1'b0;
  logic [5:0] p_score = '0, d_score = '0;
  logic       p_ready, d_ready, src_sel, blank, bust;
  logic [5:0] mag_result;

  typedef struct {
    int mag;
    bit src;
    bit blank;
    bit bust;
    bit rdy;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  // Model state: slot contents plus what the display is currently doing
  bit m_alive, m_p_ok, m_d_ok, m_showing, m_switching, m_sel, m_bust, m_blank;
  int m_p_val, m_d_val, m_mag, m_dwell, m_blink;

  score_display_sched #(.DWELL_CYCLES(DWELL), .BLINK_CYCLES(BLINK)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .p_valid    (p_valid),
    .p_score    (p_score),
    .p_ready    (p_ready),
    .d_valid    (d_valid),
    .d_score    (d_score),
    .d_ready    (d_ready),
    .hold       (hold),
    .clr        (clr),
    .mag_result (mag_result),
    .src_sel    (src_sel),
    .blank      (blank),
    .bust       (bust)
  );

  always #5 clk = ~clk;

  task automatic checkField(input string tag, input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("[TB] FAIL %s %s: got %0d, expected %0d at %0t", tag, name, act, exp, $time);
    end
  endtask

  task automatic checkOutput(input exp_t e, input string tag);
    checkField(tag, "mag_result", int'(mag_result), e.mag);
    checkField(tag, "src_sel", int'(src_sel), int'(e.src));
    checkField(tag, "blank", int'(blank), int'(e.blank));
    checkField(tag, "bust", int'(bust), int'(e.bust));
    checkField(tag, "p_ready", int'(p_ready), int'(e.rdy));
    checkField(tag, "d_ready", int'(d_ready), int'(e.rdy));
  endtask

  task automatic modelReset();
    m_alive = 0; m_p_ok = 0; m_d_ok = 0; m_showing = 0; m_switching = 0;
    m_sel = 0; m_bust = 0; m_blank = 1;
    m_p_val = 0; m_d_val = 0; m_mag = 0; m_dwell = 0; m_blink = 0;
  endtask

  function automatic exp_t modelView();
    exp_t e;
    e.mag = m_mag; e.src = m_sel; e.blank = m_blank; e.bust = m_bust;
    e.rdy = m_alive && !m_switching;
    return e;
  endfunction

  task automatic stepBlink();
    if (m_blink == BLINK - 1) begin
      m_blank = !m_blank;
      m_blink = 0;
    end else begin
      m_blink++;
    end
  endtask

  // Applies one cycle of the display rules to the model given this cycle's inputs
  task automatic modelStep(input bit pv, input int ps, input bit dv, input int ds,
                           input bit h, input bit c, output bit pw, output bit dw);
    bit rdy, other_ok, sel_w;
    int nv;
    rdy = m_alive && !m_switching;
    pw  = pv && rdy && !c;
    dw  = dv && rdy && !c;
    if (c) begin
      m_p_ok = 0; m_d_ok = 0; m_showing = 0; m_switching = 0; m_sel = 0;
      m_dwell = 0; m_blink = 0; m_bust = 0; m_blank = 1;
    end else begin
      if (pw) begin m_p_ok = 1; m_p_val = ps; end
      if (dw) begin m_d_ok = 1; m_d_val = ds; end
      if (m_switching) begin
        m_switching = 0;
      end else if (!m_showing) begin
        if (pw || dw) begin
          m_showing = 1; m_sel = !pw; m_mag = pw ? ps : ds;
          m_bust = m_mag > LIMIT; m_blank = 0; m_dwell = 0; m_blink = 0;
        end
      end else begin
        other_ok = m_sel ? m_p_ok : m_d_ok;
        sel_w    = m_sel ? dw : pw;
        if (m_dwell == DWELL - 1 && !h && other_ok) begin
          m_switching = 1; m_sel = !m_sel; m_mag = m_sel ? m_d_val : m_p_val;
          m_bust = m_mag > LIMIT; m_blank = 0; m_dwell = 0; m_blink = 0;
        end else begin
          if (!h) m_dwell = (m_dwell + 1) % DWELL;
          if (sel_w) begin
            nv = m_sel ? ds : ps;
            if (nv > LIMIT) begin
              if (!m_bust) begin m_blank = 0; m_blink = 0; end
              else stepBlink();
              m_bust = 1;
            end else begin
              m_bust = 0; m_blank = 0; m_blink = 0;
            end
            m_mag = nv;
          end else if (m_bust) begin
            stepBlink();
          end
        end
      end
    end
    m_alive = 1;
  endtask

  task automatic applyStimulus(input bit pv, input int ps, input bit dv, input int ds,
                               input bit h, input bit c, output bit pa, output bit da);
    @(negedge clk);
    p_valid = pv; p_score = 6'(ps);
    d_valid = dv; d_score = 6'(ds);
    hold = h; clr = c;
    modelStep(pv, ps, dv, ds, h, c, pa, da);
    exp_q.push_back(modelView());
  endtask

  task automatic releaseReset();
    @(negedge clk);
    p_valid = 0; d_valid = 0; hold = 0; clr = 0;
    rst_n = 1'b1;
    #1;
    checkOutput(modelView(), "release");
    m_alive = 1;
    exp_q.push_back(modelView());
  endtask

  task automatic pulseReset();
    @(negedge clk);
    p_valid = 0; d_valid = 0; hold = 0; clr = 0;
    #2 rst_n = 1'b0;
    #1;
    modelReset();
    exp_q.delete();
    checkOutput(modelView(), "async_reset");
    releaseReset();
  endtask

  function automatic int randScore();
    if ($urandom_range(0, 1) == 1) return int'($urandom_range(0, LIMIT));
    return int'($urandom_range(LIMIT + 1, 63));
  endfunction

  // Monitor: one expectation is consumed just after every rising edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput(e, "cycle");
      end
    end
  end

  initial begin
    bit pa, da, p_off, d_off, hold_r;
    int p_pend, d_pend;
    modelReset();
    repeat (2) @(negedge clk);
    #1 checkOutput(modelView(), "reset");
    releaseReset();

    applyStimulus(1, 17, 0, 0, 0, 0, pa, da);
    repeat (40) applyStimulus(0, 0, 0, 0, 0, 0, pa, da);
    applyStimulus(0, 0, 1, 20, 0, 0, pa, da);
    repeat (30) applyStimulus(0, 0, 0, 0, 0, 0, pa, da);
    applyStimulus(0, 0, 1, 24, 0, 0, pa, da);
    repeat (20) applyStimulus(0, 0, 0, 0, 0, 0, pa, da);
    applyStimulus(0, 0, 1, 19, 0, 0, pa, da);
    repeat (5) applyStimulus(0, 0, 0, 0, 0, 0, pa, da);
    applyStimulus(0, 0, 0, 0, 0, 1, pa, da);
    applyStimulus(1, 9, 1, 10, 0, 0, pa, da);
    repeat (12) applyStimulus(0, 0, 0, 0, 0, 0, pa, da);
    repeat (30) applyStimulus(0, 0, 0, 0, 1, 0, pa, da);
    applyStimulus(1, 33, 0, 0, 0, 1, pa, da);
    repeat (3) applyStimulus(0, 0, 0, 0, 0, 0, pa, da);
    applyStimulus(1, 5, 0, 0, 0, 0, pa, da);
    repeat (4) applyStimulus(0, 0, 0, 0, 0, 0, pa, da);
    pulseReset();

    // Sources hold an offer until it is accepted, as a compliant producer would
    p_off = 0; d_off = 0; hold_r = 0; p_pend = 0; d_pend = 0;
    for (int i = 0; i < 3000; i++) begin
      if (!p_off && $urandom_range(0, 5) == 0) begin p_off = 1; p_pend = randScore(); end
      if (!d_off && $urandom_range(0, 5) == 0) begin d_off = 1; d_pend = randScore(); end
      if ($urandom_range(0, 29) == 0) hold_r = !hold_r;
      if ($urandom_range(0, 999) == 0) pulseReset();
      applyStimulus(p_off, p_pend, d_off, d_pend, hold_r,
                    $urandom_range(0, 199) == 0, pa, da);
      if (pa) p_off = 0;
      if (da) d_off = 0;
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
